// File: rtl/gf2m_pkg.sv
// Shared definitions for the GF(2^m) arithmetic blocks: field degree,
// scheduler state encoding and a constant-evaluable clog2 helper.
package gf2m_pkg;

  localparam int GF_M = 163;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_e;

  // Ceiling log2, never below 1 so index fields are never zero-width.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin arbiter: the first valid requester found when
// searching upward from i_ptr (wrapping modulo N) wins.
module rr_arbiter_n
  import gf2m_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = 2
)(
  input  logic [N-1:0]     i_valid,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_grant_idx,
  output logic             o_grant_any
);

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_grant_any = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!o_grant_any && i_valid[(int'(i_ptr) + k) % N]) begin
        o_grant_any                     = 1'b1;
        o_grant[(int'(i_ptr) + k) % N]  = 1'b1;
        o_grant_idx                     = IDX_W'((int'(i_ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/gf2m_mult_sched.sv
// Shares one GF(2^m) multiplier among N_REQ requesters: round-robin accept,
// start pulse, done-or-timeout wait, then a tagged valid/ready response.
module gf2m_mult_sched
  import gf2m_pkg::*;
#(
  parameter int M       = GF_M,
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 64
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*M-1:0]   req_a,
  input  logic [N_REQ*M-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [2*M-1:0]       rsp_c,
  output logic                 rsp_err,
  output logic                 mul_start,
  output logic [M-1:0]         mul_a,
  output logic [M-1:0]         mul_b,
  input  logic                 mul_done,
  input  logic [2*M-1:0]       mul_c,
  output logic                 busy,
  output logic [15:0]          done_cnt,
  output logic [1:0]           dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1. Requesters hold valid/operands until accepted; the response holds
  // rsp_valid/rsp_id/rsp_c/rsp_err stable until rsp_ready.

  localparam int CNT_W = clog2(TIMEOUT + 1);

  sched_state_e     r_state;
  logic [ID_W-1:0]  r_ptr;
  logic [M-1:0]     r_mul_a;
  logic [M-1:0]     r_mul_b;
  logic             r_mul_start;
  logic             r_rsp_valid;
  logic [ID_W-1:0]  r_rsp_id;
  logic [2*M-1:0]   r_rsp_c;
  logic             r_rsp_err;
  logic             r_busy;
  logic [15:0]      r_done_cnt;
  logic [CNT_W-1:0] r_wait_cnt;

  logic [N_REQ-1:0] w_grant;
  logic [ID_W-1:0]  w_grant_idx;
  logic             w_grant_any;
  logic             w_accept;
  logic             w_wait_last;
  logic [M-1:0]     w_sel_a;
  logic [M-1:0]     w_sel_b;
  logic [ID_W-1:0]  w_ptr_next;

  rr_arbiter_n #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_arb (
    .i_valid     (req_valid),
    .i_ptr       (r_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_grant_any (w_grant_any)
  );

  assign req_ready   = (r_state == ST_IDLE) ? w_grant : '0;
  assign w_accept    = (r_state == ST_IDLE) && w_grant_any;
  assign w_sel_a     = req_a[int'(w_grant_idx) * M +: M];
  assign w_sel_b     = req_b[int'(w_grant_idx) * M +: M];
  // The counter is compared before its increment, so the TIMEOUT-th WAIT cycle is the last.
  assign w_wait_last = (r_wait_cnt == CNT_W'(TIMEOUT - 1));
  assign w_ptr_next  = ID_W'((int'(r_rsp_id) + 1) % N_REQ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_mul_start <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_c     <= '0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_done_cnt  <= '0;
      r_wait_cnt  <= '0;
    end else begin
      r_mul_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_mul_a     <= w_sel_a;
            r_mul_b     <= w_sel_b;
            r_rsp_id    <= w_grant_idx;
            r_mul_start <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_START;
          end
        end
        ST_START: begin
          r_wait_cnt <= '0;
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          if (mul_done) begin
            r_rsp_c     <= mul_c;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else if (w_wait_last) begin
            r_rsp_c     <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_ptr       <= w_ptr_next;
            if (!r_rsp_err) r_done_cnt <= r_done_cnt + 16'd1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_c     = r_rsp_c;
  assign rsp_err   = r_rsp_err;
  assign mul_start = r_mul_start;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign busy      = r_busy;
  assign done_cnt  = r_done_cnt;
  assign dbg_state = r_state;

endmodule
